// File: rtl/path_pkg.sv
// path_pkg: shared codes for the path turn planner.
// Directions, turns, FSM states, error codes, entry slicing.
package path_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    TURN_STRAIGHT = 2'd0,
    TURN_RIGHT    = 2'd1,
    TURN_U        = 2'd2,
    TURN_LEFT     = 2'd3
  } turn_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_SEARCH    = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_NODE = 3'd4,
    S_DONE      = 3'd5,
    S_ERR       = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_ADJ  = 2'd1,
    ERR_OVF  = 2'd2,
    ERR_OVR  = 2'd3
  } err_e;

  // Bit offset of the {v,id} field for direction d; N is the top field.
  function automatic int fld_off(input logic [1:0] d, input int nw);
    return (3 - int'(d)) * (nw + 1);
  endfunction

endpackage

// File: rtl/path_turn_planner_adj_table.sv
// adj_table: adjacency register array, one write port
// and one registered read port.
module adj_table #(
  parameter int NODE_W    = 5,
  parameter int NUM_NODES = 30,
  localparam int EW       = 4 * (NODE_W + 1)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NODE_W-1:0] waddr,
  input  logic [EW-1:0]     wdata,
  input  logic              re,
  input  logic [NODE_W-1:0] raddr,
  output logic [EW-1:0]     rdata
);

  localparam logic [NODE_W:0] LIMIT = (NODE_W + 1)'(NUM_NODES);

  logic [EW-1:0] mem_q [NUM_NODES];
  logic [EW-1:0] rdata_q;
  logic          w_ok;
  logic          r_ok;

  assign w_ok  = ({1'b0, waddr} < LIMIT);
  assign r_ok  = ({1'b0, raddr} < LIMIT);
  assign rdata = rdata_q;

  // Table storage; out-of-range writes are dropped, no reset.
  always_ff @(posedge clk) begin
    if (we && w_ok) mem_q[waddr] <= wdata;
  end

  // Registered read; out-of-range nodes read as no neighbours.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= r_ok ? mem_q[raddr] : '0;
  end

endmodule

// File: rtl/path_turn_planner.sv
// path_turn_planner: walks a loaded node path over the
// adjacency map and issues one turn per hop.
module path_turn_planner
  import path_pkg::*;
#(
  parameter int NODE_W     = 5,
  parameter int NUM_NODES  = 30,
  parameter int PATH_DEPTH = 16,
  localparam int LW        = $clog2(PATH_DEPTH + 1),
  localparam int EW        = 4 * (NODE_W + 1)
) (
  input  logic              clk_3125KHz,
  input  logic              rst,
  input  logic              tbl_we,
  input  logic [NODE_W-1:0] tbl_addr,
  input  logic [EW-1:0]     tbl_data,
  input  logic              path_we,
  input  logic [NODE_W-1:0] path_node,
  input  logic              path_start,
  input  logic [1:0]        start_dir,
  input  logic              abort,
  input  logic              node_event,
  input  logic              turn_ready,
  output logic              turn_valid,
  output logic [1:0]        turn,
  output logic [NODE_W-1:0] curr_node,
  output logic [1:0]        heading,
  output logic [LW-1:0]     path_len,
  output logic              busy,
  output logic              path_done,
  output logic              path_err,
  output logic [1:0]        err_code
);

  localparam int IW = $clog2(PATH_DEPTH);
  localparam logic [LW-1:0] DEPTH = LW'(PATH_DEPTH);

  state_e            state_q, state_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     path_len_q, path_len_d;
  logic [1:0]        dir_q, dir_d;
  logic [1:0]        nxt_dir_q, nxt_dir_d;
  logic [NODE_W-1:0] next_q, next_d;
  logic [NODE_W-1:0] curr_node_q, curr_node_d;
  logic [1:0]        heading_q, heading_d;
  logic [1:0]        turn_q, turn_d;
  logic              turn_valid_q, turn_valid_d;
  logic              path_done_q, path_done_d;
  logic              path_err_q, path_err_d;
  err_e              err_code_q, err_code_d;

  logic [NODE_W-1:0] path_buf_q [PATH_DEPTH];
  logic              path_wr;
  logic [EW-1:0]     ent;
  logic [LW-1:0]     nxt_idx;
  int                off;
  logic              v_sel;
  logic [NODE_W-1:0] id_sel;

  adj_table #(
    .NODE_W    (NODE_W),
    .NUM_NODES (NUM_NODES)
  ) u_tbl (
    .clk   (clk_3125KHz),
    .we    (tbl_we && (state_q == S_IDLE)),
    .waddr (tbl_addr),
    .wdata (tbl_data),
    .re    (state_q == S_FETCH),
    .raddr (curr_node_q),
    .rdata (ent)
  );

  assign nxt_idx = idx_q + 1'b1;

  // Pick the {v,id} field for the direction under test.
  always_comb begin
    off    = fld_off(dir_q, NODE_W);
    id_sel = ent[off +: NODE_W];
    v_sel  = ent[off + NODE_W];
  end

  // Next-state logic; abort beats start beats node_event.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    path_len_d   = path_len_q;
    dir_d        = dir_q;
    nxt_dir_d    = nxt_dir_q;
    next_d       = next_q;
    curr_node_d  = curr_node_q;
    heading_d    = heading_q;
    turn_d       = turn_q;
    turn_valid_d = turn_valid_q;
    path_done_d  = path_done_q;
    path_err_d   = path_err_q;
    err_code_d   = err_code_q;
    path_wr      = 1'b0;
    if (abort) begin
      state_d      = S_IDLE;
      path_len_d   = '0;
      turn_valid_d = 1'b0;
      path_done_d  = 1'b0;
      path_err_d   = 1'b0;
      err_code_d   = ERR_NONE;
    end else if (path_start) begin
      idx_d        = '0;
      curr_node_d  = path_buf_q[0];
      heading_d    = start_dir;
      turn_valid_d = 1'b0;
      path_done_d  = 1'b0;
      path_err_d   = 1'b0;
      err_code_d   = ERR_NONE;
      if (path_len_q == '0) begin
        state_d    = S_ERR;
        path_err_d = 1'b1;
        err_code_d = ERR_ADJ;
      end else if (path_len_q == LW'(1)) begin
        state_d     = S_DONE;
        path_done_d = 1'b1;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (path_we) begin
            if (path_len_q == DEPTH) begin
              path_err_d = 1'b1;
              err_code_d = ERR_OVF;
            end else begin
              path_wr    = 1'b1;
              path_len_d = path_len_q + 1'b1;
            end
          end
        end
        S_FETCH, S_SEARCH, S_ISSUE: begin
          if (node_event) begin
            state_d      = S_ERR;
            turn_valid_d = 1'b0;
            path_err_d   = 1'b1;
            err_code_d   = ERR_OVR;
          end else if (state_q == S_FETCH) begin
            next_d  = path_buf_q[nxt_idx[IW-1:0]];
            dir_d   = DIR_N;
            state_d = S_SEARCH;
          end else if (state_q == S_SEARCH) begin
            if (v_sel && (id_sel == next_q)) begin
              nxt_dir_d    = dir_q;
              turn_d       = dir_q - heading_q;
              turn_valid_d = 1'b1;
              state_d      = S_ISSUE;
            end else if (dir_q == DIR_W) begin
              state_d    = S_ERR;
              path_err_d = 1'b1;
              err_code_d = ERR_ADJ;
            end else begin
              dir_d = dir_q + 2'd1;
            end
          end else if (turn_ready) begin
            turn_valid_d = 1'b0;
            heading_d    = nxt_dir_q;
            state_d      = S_WAIT_NODE;
          end
        end
        S_WAIT_NODE: begin
          if (node_event) begin
            idx_d       = nxt_idx;
            curr_node_d = next_q;
            if (nxt_idx == path_len_q - 1'b1) begin
              state_d     = S_DONE;
              path_done_d = 1'b1;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
        S_DONE, S_ERR: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge clk_3125KHz) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      path_len_q   <= '0;
      dir_q        <= DIR_N;
      nxt_dir_q    <= DIR_N;
      next_q       <= '0;
      curr_node_q  <= '0;
      heading_q    <= DIR_N;
      turn_q       <= TURN_STRAIGHT;
      turn_valid_q <= 1'b0;
      path_done_q  <= 1'b0;
      path_err_q   <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      path_len_q   <= path_len_d;
      dir_q        <= dir_d;
      nxt_dir_q    <= nxt_dir_d;
      next_q       <= next_d;
      curr_node_q  <= curr_node_d;
      heading_q    <= heading_d;
      turn_q       <= turn_d;
      turn_valid_q <= turn_valid_d;
      path_done_q  <= path_done_d;
      path_err_q   <= path_err_d;
      err_code_q   <= err_code_d;
    end
  end

  // Path buffer append; contents are dead once path_len is cleared.
  always_ff @(posedge clk_3125KHz) begin
    if (path_wr) path_buf_q[path_len_q[IW-1:0]] <= path_node;
  end

  assign turn_valid = turn_valid_q;
  assign turn       = turn_q;
  assign curr_node  = curr_node_q;
  assign heading    = heading_q;
  assign path_len   = path_len_q;
  assign busy       = (state_q != S_IDLE);
  assign path_done  = path_done_q;
  assign path_err   = path_err_q;
  assign err_code   = err_code_q;

endmodule
